// File: rtl/xnor_compare_arbiter.sv
// Two-requester round-robin arbiter that XNORs the granted operand pair and counts matching bits.
// Build option: define XNOR_ARB_PARALLEL_EN for a single-cycle popcount instead of the 8-cycle serial count.
module xnor_compare_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic       req1,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       busy,
    output logic       done,
    output logic       done_id,
    output logic [7:0] xnor_out,
    output logic [3:0] match_cnt,
    output logic       equal
);

    // state | meaning
    // IDLE  | waiting for a request; arbitration happens here
    // COUNT | counting ones of the latched xnor result
    // DONE  | result outputs valid, done pulse high
    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t     state, state_nxt;
    logic       prio;
    logic       job_id;
    logic       grant_vld;
    logic       grant_id;
    logic [7:0] ld_xnor;
    logic [3:0] cnt_nxt;
    logic       count_tc;

`ifdef XNOR_ARB_PARALLEL_EN
    always_comb begin
        cnt_nxt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt_nxt = cnt_nxt + {3'd0, xnor_out[i]};
        end
    end

    assign count_tc = 1'b1;
`else
    logic [7:0] shreg;
    logic [3:0] cnt;
    logic [2:0] tmr;

    assign cnt_nxt  = cnt + {3'd0, shreg[0]};
    assign count_tc = (tmr == 3'd0);
`endif

    // prio = 1 means requester 1 is preferred when both are asking
    assign grant_vld = (state == IDLE) && (req0 || req1);
    assign grant_id  = req1 && (!req0 || prio);
    assign ld_xnor   = grant_id ? ~(a1 ^ b1) : ~(a0 ^ b0);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = COUNT;
            COUNT:   if (count_tc)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done      <= 1'b0;
            done_id   <= 1'b0;
            xnor_out  <= 8'h00;
            match_cnt <= 4'd0;
            equal     <= 1'b0;
            prio      <= 1'b0;
            job_id    <= 1'b0;
`ifndef XNOR_ARB_PARALLEL_EN
            shreg     <= 8'h00;
            cnt       <= 4'd0;
            tmr       <= 3'd0;
`endif
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done <= 1'b0;

            if (grant_vld) begin
                gnt0     <= !grant_id;
                gnt1     <= grant_id;
                job_id   <= grant_id;
                prio     <= !grant_id;
                xnor_out <= ld_xnor;
`ifndef XNOR_ARB_PARALLEL_EN
                shreg    <= ld_xnor;
                cnt      <= 4'd0;
                tmr      <= 3'd7;
`endif
            end

            if (state == COUNT) begin
`ifndef XNOR_ARB_PARALLEL_EN
                cnt   <= cnt_nxt;
                shreg <= shreg >> 1;
                tmr   <= tmr - 3'd1;
`endif
                if (count_tc) begin
                    done      <= 1'b1;
                    match_cnt <= cnt_nxt;
                    equal     <= (cnt_nxt == 4'd8);
                    done_id   <= job_id;
                end
            end
        end
    end

endmodule

// File: tb/tb_xnor_compare_arbiter.sv
// Directed bench for xnor_compare_arbiter; define XNOR_ARB_PARALLEL_EN to check the single-cycle count build.
module tb_xnor_compare_arbiter;

`ifdef XNOR_ARB_PARALLEL_EN
    localparam int DONE_CYC = 2;
`else
    localparam int DONE_CYC = 9;
`endif

    logic       clk;
    logic       reset;
    logic       req0, req1;
    logic [7:0] a0, b0, a1, b1;
    logic       gnt0, gnt1, busy, done, done_id, equal;
    logic [7:0] xnor_out;
    logic [3:0] match_cnt;

    int vectors = 0;
    int errors  = 0;

    xnor_compare_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .a0        (a0),
        .b0        (b0),
        .req1      (req1),
        .a1        (a1),
        .b1        (b1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
        .xnor_out  (xnor_out),
        .match_cnt (match_cnt),
        .equal     (equal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gnt0"}, gnt0, 0);
        chk({tag, "_gnt1"}, gnt1, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_done_id"}, done_id, 0);
        chk({tag, "_equal"}, equal, 0);
        chk({tag, "_xnor_out"}, xnor_out, 8'h00);
        chk({tag, "_match_cnt"}, match_cnt, 4'd0);
    endtask

    // Called on the negedge of the grant cycle (cycle 1); returns on the done cycle.
    task automatic run_job(input string tag, input logic id, input logic [7:0] ex,
                           input logic [3:0] ec, input logic eeq);
        int   cyc;
        logic seen;
        chk({tag, "_gnt0"}, gnt0, !id);
        chk({tag, "_gnt1"}, gnt1, id);
        chk({tag, "_busy_grant"}, busy, 1);
        chk({tag, "_done_at_grant"}, done, 0);
        chk({tag, "_xnor_load"}, xnor_out, ex);
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
            else begin
                chk({tag, "_busy_count"}, busy, 1);
                chk({tag, "_gnt_count"}, gnt0 | gnt1, 0);
            end
        end
        chk({tag, "_done_cycle"}, cyc, DONE_CYC);
        chk({tag, "_busy_done"}, busy, 1);
        chk({tag, "_match_cnt"}, match_cnt, ec);
        chk({tag, "_equal"}, equal, eeq);
        chk({tag, "_done_id"}, done_id, id);
        chk({tag, "_xnor_out"}, xnor_out, ex);
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("rst");

        // Identical operands from requester 0
        reset = 1'b0;
        req0 = 1'b1; a0 = 8'hA5; b0 = 8'hA5;
        @(negedge clk);
        req0 = 1'b0;
        run_job("eq0", 1'b0, 8'hFF, 4'd8, 1'b1);
        @(negedge clk);
        chk("eq0_done_pulse", done, 0);
        chk("eq0_idle_busy", busy, 0);
        chk("eq0_hold_cnt", match_cnt, 4'd8);
        chk("eq0_hold_equal", equal, 1);

        // Complementary operands from requester 1
        req1 = 1'b1; a1 = 8'hF0; b1 = 8'h0F;
        @(negedge clk);
        req1 = 1'b0;
        run_job("ne1", 1'b1, 8'h00, 4'd0, 1'b0);
        @(negedge clk);

        // Requester 1 alone while pointer prefers requester 0 still wins
        req1 = 1'b1; a1 = 8'h0F; b1 = 8'h0E;
        @(negedge clk);
        req1 = 1'b0;
        run_job("solo1", 1'b1, 8'hFE, 4'd7, 1'b0);
        @(negedge clk);

        // Operand change right after the grant must not affect the job
        req0 = 1'b1; a0 = 8'h00; b0 = 8'h0F;
        @(negedge clk);
        req0 = 1'b0; a0 = 8'hFF;
        run_job("opchg", 1'b0, 8'hF0, 4'd4, 1'b0);
        @(negedge clk);

        // Reset wins over simultaneous requests
        reset = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        a0 = 8'h3C; b0 = 8'h3D; a1 = 8'h3C; b1 = 8'h3D;
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("rst_req");

        // Both requesting continuously: strict alternation, no overlap
        reset = 1'b0;
        @(negedge clk);
        run_job("rr_a", 1'b0, 8'hFE, 4'd7, 1'b0);
        @(negedge clk);
        chk("rr_a_gap_busy", busy, 0);
        chk("rr_a_gap_gnt", gnt0 | gnt1, 0);
        @(negedge clk);
        run_job("rr_b", 1'b1, 8'hFE, 4'd7, 1'b0);
        @(negedge clk);
        chk("rr_b_gap_busy", busy, 0);
        @(negedge clk);
        run_job("rr_c", 1'b0, 8'hFE, 4'd7, 1'b0);
        @(negedge clk);
        chk("rr_c_gap_busy", busy, 0);
        @(negedge clk);
        run_job("rr_d", 1'b1, 8'hFE, 4'd7, 1'b0);
        req1 = 1'b0;

        // Reset in cycle 4 of a job aborts it
        @(negedge clk);
        chk("abort_idle", busy, 0);
        @(negedge clk);
        chk("abort_gnt0", gnt0, 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("abort");
        reset = 1'b0;
        @(negedge clk);
        chk("abort_regrant_gnt0", gnt0, 1);
        req0 = 1'b0;
        run_job("post_abort", 1'b0, 8'hFE, 4'd7, 1'b0);
        @(negedge clk);
        chk("post_abort_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
